// File: rtl/control_sequencer_if.sv
// Memory beat bus between control_sequencer (master) and the memory port (slave).
// The beat width follows MEMORY_BUS_WIDTH; beat_index is at least one bit wide.
interface control_sequencer_if #(
  parameter int MEMORY_BUS_WIDTH = 8
);
  localparam int BEATS  = 32 / MEMORY_BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Handshake: a beat completes in every cycle where memory_request and
  // memory_ready are both high; memory_ready alone carries no meaning.
  logic                        memory_request;
  logic                        memory_write;
  logic                        memory_address_select;
  logic                        memory_ready;
  logic [MEMORY_BUS_WIDTH-1:0] memory_read_data;
  logic [BEAT_W-1:0]           beat_index;

  modport master (
    output memory_request,
    output memory_write,
    output memory_address_select,
    output beat_index,
    input  memory_ready,
    input  memory_read_data
  );

  modport slave (
    input  memory_request,
    input  memory_write,
    input  memory_address_select,
    input  beat_index,
    output memory_ready,
    output memory_read_data
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I control sequencer: fetches over a narrow beat bus and steps
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. Define CONTROL_SEQUENCER_HALT_EN to stop on EBREAK/unknown opcodes.
module control_sequencer #(
  parameter int MEMORY_BUS_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  control_sequencer_if.master        mem,
  output logic [31:0]                instruction,
  output logic                       branch,
  output logic                       alu_operand_1_source,
  output logic                       alu_operand_2_source,
  output logic [3:0]                 alu_operation,
  output logic                       memory_write_enable,
  output logic                       register_write_enable,
  output logic [1:0]                 register_write_data_source,
  output logic                       program_counter_write_enable,
  output logic                       halted,
  output logic [2:0]                 debug_state
);
  localparam int                BEATS     = 32 / MEMORY_BUS_WIDTH;
  localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // debug_state encoding: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 5 HALTED
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
`ifdef CONTROL_SEQUENCER_HALT_EN
    , S_HALTED  = 3'd5
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       instr_q, instr_d;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              in_beat_state;
  logic              beat_done;
  logic              last_beat_done;
  logic              known_opcode;

  assign opcode         = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign in_beat_state  = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign beat_done      = in_beat_state && mem.memory_ready;
  assign last_beat_done = beat_done && (beat_q == LAST_BEAT);

  always_comb begin
    unique case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI: known_opcode = 1'b1;
      default:                                known_opcode = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
      instr_q <= 32'h0000_0013;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    instr_d = instr_q;
    if (beat_done) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end
    if (beat_done && (state_q == S_FETCH)) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BEAT_W'(b)) begin
          instr_d[b*MEMORY_BUS_WIDTH +: MEMORY_BUS_WIDTH] = mem.memory_read_data;
        end
      end
    end
    case (state_q)
      S_FETCH:     if (last_beat_done) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          state_d = S_MEMORY;
        end else begin
`ifdef CONTROL_SEQUENCER_HALT_EN
          state_d = known_opcode ? S_WRITEBACK : S_HALTED;
`else
          state_d = S_WRITEBACK;
`endif
        end
      end
      S_MEMORY:    if (last_beat_done) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = state_q;
    endcase
  end

  always_comb begin
    mem.memory_request           = in_beat_state && !reset;
    mem.memory_write             = 1'b0;
    mem.memory_address_select    = 1'b0;
    branch                       = 1'b0;
    alu_operand_1_source         = 1'b0;
    alu_operand_2_source         = 1'b0;
    alu_operation                = 4'b0000;
    memory_write_enable          = 1'b0;
    register_write_enable        = 1'b0;
    register_write_data_source   = 2'd0;
    program_counter_write_enable = 1'b0;
    case (state_q)
      S_EXECUTE: begin
        case (opcode)
          OPC_OP:     alu_operation = {instr_q[30], funct3};
          OPC_OP_IMM: begin
            alu_operand_2_source = 1'b1;
            alu_operation        = {(funct3 == 3'b101) ? instr_q[30] : 1'b0, funct3};
          end
          OPC_LOAD, OPC_STORE, OPC_JALR: alu_operand_2_source = 1'b1;
          OPC_BRANCH: begin
            alu_operation = 4'b1000;
            branch        = 1'b1;
          end
          OPC_JAL, OPC_AUIPC: begin
            alu_operand_1_source = 1'b1;
            alu_operand_2_source = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        mem.memory_address_select = 1'b1;
        mem.memory_write          = (opcode == OPC_STORE);
        memory_write_enable       = (opcode == OPC_STORE);
      end
      S_WRITEBACK: begin
        program_counter_write_enable = 1'b1;
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_AUIPC: register_write_enable = 1'b1;
          OPC_LUI: begin
            register_write_enable      = 1'b1;
            register_write_data_source = 2'd1;
          end
          OPC_LOAD: begin
            register_write_enable      = 1'b1;
            register_write_data_source = 2'd2;
          end
          OPC_JAL, OPC_JALR: begin
            register_write_enable      = 1'b1;
            register_write_data_source = 2'd3;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign mem.beat_index = beat_q;
  assign instruction    = instr_q;
  assign debug_state    = state_q;
`ifdef CONTROL_SEQUENCER_HALT_EN
  assign halted = (state_q == S_HALTED);
`else
  assign halted = 1'b0 & known_opcode;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: width-8 instance for the instruction mix,
// stalls and mid-beat reset; width-32 instance for the single-beat store.
module tb_control_sequencer;
  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEMORY    = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  control_sequencer_if #(.MEMORY_BUS_WIDTH(8))  mem8 ();
  control_sequencer_if #(.MEMORY_BUS_WIDTH(32)) mem32 ();

  logic [31:0] instr8, instr32;
  logic        branch8, branch32, op1_8, op1_32, op2_8, op2_32;
  logic [3:0]  alu8, alu32;
  logic        mwe8, mwe32, rwe8, rwe32, pcwe8, pcwe32, halted8, halted32;
  logic [1:0]  src8, src32;
  logic [2:0]  state8, state32;

  control_sequencer #(.MEMORY_BUS_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .mem(mem8),
    .instruction(instr8), .branch(branch8),
    .alu_operand_1_source(op1_8), .alu_operand_2_source(op2_8),
    .alu_operation(alu8), .memory_write_enable(mwe8),
    .register_write_enable(rwe8), .register_write_data_source(src8),
    .program_counter_write_enable(pcwe8), .halted(halted8), .debug_state(state8)
  );

  control_sequencer #(.MEMORY_BUS_WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .mem(mem32),
    .instruction(instr32), .branch(branch32),
    .alu_operand_1_source(op1_32), .alu_operand_2_source(op2_32),
    .alu_operation(alu32), .memory_write_enable(mwe32),
    .register_write_enable(rwe32), .register_write_data_source(src32),
    .program_counter_write_enable(pcwe32), .halted(halted32), .debug_state(state32)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick8(input logic rdy, input logic [7:0] data);
    mem8.memory_ready     = rdy;
    mem8.memory_read_data = data;
    @(negedge clock);
  endtask

  // Runs one instruction on the width-8 DUT starting in FETCH beat 0 and checks
  // every control output in every cycle against hand-given EXECUTE/WRITEBACK fields.
  task automatic run8(input string name, input logic [31:0] word, input bit stall,
                      input logic [3:0] e_alu, input bit e_op1, input bit e_op2,
                      input bit e_br, input bit e_rwe, input logic [1:0] e_src,
                      input int e_total);
    logic [2:0] st;
    logic [1:0] bt;
    logic [7:0] data;
    bit         is_mem, is_store, rdy, done, in_beat;
    int         wb_cycle;
    is_store = (word[6:0] == 7'b0100011);
    is_mem   = is_store || (word[6:0] == 7'b0000011);
    st       = ST_FETCH;
    bt       = 2'd0;
    done     = 1'b0;
    wb_cycle = 0;
    exp_q.push_back(word);
    for (int c = 1; c <= 40 && !done; c++) begin
      rdy     = stall ? (c % 2 == 0) : 1'b1;
      in_beat = (st == ST_FETCH) || (st == ST_MEMORY);
      if (state8 == ST_WRITEBACK && wb_cycle == 0) wb_cycle = c;
      check_eq({name, " state"},     32'(state8), 32'(st));
      check_eq({name, " beat"},      32'(mem8.beat_index), 32'(bt));
      check_eq({name, " request"},   32'(mem8.memory_request), 32'(in_beat));
      check_eq({name, " addr_sel"},  32'(mem8.memory_address_select), 32'(st == ST_MEMORY));
      check_eq({name, " mem_write"}, 32'(mem8.memory_write), 32'(st == ST_MEMORY && is_store));
      check_eq({name, " mem_we"},    32'(mwe8), 32'(st == ST_MEMORY && is_store));
      check_eq({name, " branch"},    32'(branch8), 32'(st == ST_EXECUTE && e_br));
      check_eq({name, " alu_op"},    32'(alu8), (st == ST_EXECUTE) ? 32'(e_alu) : 32'd0);
      check_eq({name, " op1_src"},   32'(op1_8), 32'(st == ST_EXECUTE && e_op1));
      check_eq({name, " op2_src"},   32'(op2_8), 32'(st == ST_EXECUTE && e_op2));
      check_eq({name, " reg_we"},    32'(rwe8), 32'(st == ST_WRITEBACK && e_rwe));
      check_eq({name, " wb_src"},    32'(src8), (st == ST_WRITEBACK) ? 32'(e_src) : 32'd0);
      check_eq({name, " pc_we"},     32'(pcwe8), 32'(st == ST_WRITEBACK));
      check_eq({name, " halted"},    32'(halted8), 32'd0);
      if (st == ST_DECODE) check_eq({name, " instruction"}, instr8, exp_q.pop_front());
      data = 8'(word >> (8 * bt));
      tick8(rdy, data);
      if (in_beat && rdy) begin
        if (bt == 2'd3) begin
          bt = 2'd0;
          st = (st == ST_FETCH) ? ST_DECODE : ST_WRITEBACK;
        end else begin
          bt = bt + 2'd1;
        end
      end else if (st == ST_DECODE) begin
        st = ST_EXECUTE;
      end else if (st == ST_EXECUTE) begin
        st = is_mem ? ST_MEMORY : ST_WRITEBACK;
      end else if (st == ST_WRITEBACK) begin
        st   = ST_FETCH;
        done = 1'b1;
      end
    end
    check_eq({name, " cycles"}, 32'(wb_cycle), 32'(e_total));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] est;
    mem8.memory_ready      = 1'b1;
    mem8.memory_read_data  = 8'h00;
    mem32.memory_ready     = 1'b0;
    mem32.memory_read_data = 32'h0;
    #1;
    check_eq("rst request8",  32'(mem8.memory_request), 32'd0);
    check_eq("rst request32", 32'(mem32.memory_request), 32'd0);
    @(negedge clock);
    @(negedge clock);
    check_eq("rst state",       32'(state8), 32'(ST_FETCH));
    check_eq("rst beat",        32'(mem8.beat_index), 32'd0);
    check_eq("rst instruction", instr8, 32'h0000_0013);
    check_eq("rst halted",      32'(halted8), 32'd0);
    check_eq("rst pc_we",       32'(pcwe8), 32'd0);
    check_eq("rst reg_we",      32'(rwe8), 32'd0);
    check_eq("rst request",     32'(mem8.memory_request), 32'd0);
    check_eq("rst instr32",     instr32, 32'h0000_0013);
    mem8.memory_ready = 1'b0;
    reset = 1'b0;
    #1;

    // Width-32 store: one beat per phase, 5 cycles; width-8 DUT stalls meanwhile.
    mem32.memory_ready     = 1'b1;
    mem32.memory_read_data = 32'h0020_A023;
    check_eq("sw32 c1 state",   32'(state32), 32'(ST_FETCH));
    check_eq("sw32 c1 request", 32'(mem32.memory_request), 32'd1);
    check_eq("sw32 c1 beat",    32'(mem32.beat_index), 32'd0);
    @(negedge clock);
    check_eq("sw32 c2 state",   32'(state32), 32'(ST_DECODE));
    check_eq("sw32 c2 instr",   instr32, 32'h0020_A023);
    check_eq("sw32 c2 request", 32'(mem32.memory_request), 32'd0);
    @(negedge clock);
    check_eq("sw32 c3 state",   32'(state32), 32'(ST_EXECUTE));
    check_eq("sw32 c3 op2_src", 32'(op2_32), 32'd1);
    check_eq("sw32 c3 alu_op",  32'(alu32), 32'd0);
    @(negedge clock);
    check_eq("sw32 c4 state",     32'(state32), 32'(ST_MEMORY));
    check_eq("sw32 c4 addr_sel",  32'(mem32.memory_address_select), 32'd1);
    check_eq("sw32 c4 mem_write", 32'(mem32.memory_write), 32'd1);
    check_eq("sw32 c4 mem_we",    32'(mwe32), 32'd1);
    @(negedge clock);
    check_eq("sw32 c5 state",     32'(state32), 32'(ST_WRITEBACK));
    check_eq("sw32 c5 pc_we",     32'(pcwe32), 32'd1);
    check_eq("sw32 c5 reg_we",    32'(rwe32), 32'd0);
    check_eq("sw32 c5 mem_we",    32'(mwe32), 32'd0);
    @(negedge clock);
    mem32.memory_ready = 1'b0;
    check_eq("sw32 c6 state", 32'(state32), 32'(ST_FETCH));
    check_eq("sw32 c6 pc_we", 32'(pcwe32), 32'd0);
    check_eq("stall8 state",  32'(state8), 32'(ST_FETCH));
    check_eq("stall8 beat",   32'(mem8.beat_index), 32'd0);
    check_eq("stall8 instr",  instr8, 32'h0000_0013);

    //    name       word          stall alu      o1 o2 br we src   cycles
    run8("add",     32'h002081B3, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 7);
    run8("sub",     32'h40208133, 0, 4'b1000, 0, 0, 0, 1, 2'd0, 7);
    run8("srai",    32'h4020D093, 0, 4'b1101, 0, 1, 0, 1, 2'd0, 7);
    run8("addi30",  32'h40000093, 0, 4'b0000, 0, 1, 0, 1, 2'd0, 7);
    run8("lw_stall",32'h0000A103, 1, 4'b0000, 0, 1, 0, 1, 2'd2, 19);
    run8("sw8",     32'h0020A023, 0, 4'b0000, 0, 1, 0, 0, 2'd0, 11);
    run8("beq",     32'h00208463, 0, 4'b1000, 0, 0, 1, 0, 2'd0, 7);
    run8("jal",     32'h008000EF, 0, 4'b0000, 1, 1, 0, 1, 2'd3, 7);
    run8("jalr",    32'h000080E7, 0, 4'b0000, 0, 1, 0, 1, 2'd3, 7);
    run8("auipc",   32'h00001097, 0, 4'b0000, 1, 1, 0, 1, 2'd0, 7);
    run8("lui",     32'h000010B7, 0, 4'b0000, 0, 0, 0, 1, 2'd1, 7);

    // Reset dropped into the third fetch beat.
    tick8(1'b1, 8'hEF);
    tick8(1'b1, 8'hBE);
    check_eq("abort beat",    32'(mem8.beat_index), 32'd2);
    check_eq("abort partial", {16'h0, instr8[15:0]}, 32'h0000_BEEF);
    mem8.memory_read_data = 8'hAD;
    #2 reset = 1'b1;
    #1;
    check_eq("abort request", 32'(mem8.memory_request), 32'd0);
    check_eq("abort beat0",   32'(mem8.beat_index), 32'd0);
    check_eq("abort instr",   instr8, 32'h0000_0013);
    check_eq("abort state",   32'(state8), 32'(ST_FETCH));
    @(negedge clock);
    check_eq("abort hold request", 32'(mem8.memory_request), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("restart request", 32'(mem8.memory_request), 32'd1);
    check_eq("restart instr",   instr8, 32'h0000_0013);
    run8("restart_add", 32'h002081B3, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 7);

`ifdef CONTROL_SEQUENCER_HALT_EN
    for (int c = 1; c <= 9; c++) begin
      est = (c <= 4) ? ST_FETCH : (c == 5) ? ST_DECODE : (c == 6) ? ST_EXECUTE : ST_HALTED;
      check_eq("ebreak state",  32'(state8), 32'(est));
      check_eq("ebreak halted", 32'(halted8), 32'(c >= 7));
      check_eq("ebreak pc_we",  32'(pcwe8), 32'd0);
      check_eq("ebreak reg_we", 32'(rwe8), 32'd0);
      if (c >= 5) check_eq("ebreak request", 32'(mem8.memory_request), 32'd0);
      tick8(1'b1, 8'(32'h00100073 >> (8 * (c - 1))));
    end
`else
    est = ST_FETCH;
    run8("ebreak", 32'h00100073, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 7);
    check_eq("ebreak next fetch",   32'(state8), 32'(est));
    check_eq("ebreak next request", 32'(mem8.memory_request), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
